scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Scan-order controller for the 150×150 edge-detection datapath. On `start` it runs up to four full-frame passes: left-right, up-down, down-left diagonal and down-right diagonal. Each pass issues pixel addresses to pixel memory under a valid/stall handshake. It asserts `lineReset` on the last pixel of every row, column or diagonal so the edge detector clears its state between lines. It replaces free-running counting with a sequenced, back-pressured address stream.

## Interface
- `N`, 150, image side length in pixels (2 ≤ N ≤ 181)
- `ADDR_W`, 15, address width; must satisfy N² ≤ 2^ADDR_W
- `clk` in 1 — clock, rising edge
- `resetIn` in 1 — reset, asynchronous, active-high
- `start` in 1 — begin a scan sequence; sampled only in IDLE
- `abort` in 1 — synchronous cancel of the running sequence
- `modeMask` in 4 — pass enables: bit0 LR, bit1 UD, bit2 DL, bit3 DR; sampled with `start`
- `stall` in 1 — consumer not ready; the current address is held
- `addr` out ADDR_W — pixel address, row*N + col
- `addrValid` out 1 — `addr` is a valid element
- `lineReset` out 1 — current element is the last of its line
- `passMode` out 2 — current pass: 0 LR, 1 UD, 2 DL, 3 DR
- `busy` out 1 — high from the cycle after an accepted start until DONE
- `done` out 1 — one-cycle pulse at completion

## Operation
- States: IDLE, LR, UD, DL, DR, DONE.
- Passes always run in the order LR→UD→DL→DR. Passes with a mask bit of 0 are skipped.
- An element is accepted when `addrValid && !stall`.
- LR pass:
  - Row-major: row 0..N-1, col 0..N-1.
  - Line ends at col = N-1.
- UD pass:
  - Column-major: col 0..N-1, row 0..N-1.
  - Line ends at row = N-1.
- DL pass:
  - Diagonals k = 0..2N-2 contain the cells where row+col = k.
  - Each diagonal starts at row = max(0, k-N+1), col = k-row, then steps row+1, col-1.
  - Line ends at row = N-1 or col = 0.
- DR pass:
  - Diagonals k = 0..2N-2 contain the cells where col-row = k-(N-1).
  - Each diagonal starts at row = max(0, N-1-k), col = row+k-(N-1), then steps row+1, col+1.
  - Line ends at row = N-1 or col = N-1.
- Line counts and lengths:
  - Every pass issues exactly N² elements.
  - LR and UD have N lines each. DL and DR have 2N-1 lines each.
- Internal widths:
  - row and col: 8-bit unsigned.
  - Diagonal index k: 9-bit unsigned.
  - The `addr` multiply is unsigned. It is computed from the next row/col, so `addr` is registered with no extra latency.
- Passing `start` with `modeMask` = 0 goes directly IDLE→DONE.
- `start` is ignored while `busy`.
- `abort`:
  - From any non-IDLE state, go to IDLE next cycle.
  - `addrValid`, `lineReset` and `busy` deassert; no `done` pulse.
  - `abort` has priority over an element acceptance in the same cycle.
- `resetIn` mid-pass returns the block immediately to IDLE with all outputs at their reset values.

## Timing
- Reset values: `addr` 0, `addrValid` 0, `lineReset` 0, `passMode` 0, `busy` 0, `done` 0.
- Start latency: `start` sampled high in IDLE in cycle T → in T+1 `busy`=1, `addrValid`=1, and `addr`/`passMode` show the first element of the first enabled pass.
- With `stall` low, one element is issued per cycle.
- While `stall` is high, `addr`, `lineReset` and `passMode` hold; `addrValid` stays 1.
- `lineReset` is coincident with `addrValid` on the final element of a line. It drops on the next element.
- Pass boundaries have no bubble: the cycle after the last element of a pass is accepted, the first element of the next enabled pass is presented.
- After the last element of the last enabled pass is accepted:
  - The block enters DONE for one cycle with `done`=1, `busy`=0, `addrValid`=0.
  - It then returns to IDLE.
- Sequence length with no stalls and all four passes enabled: 4N² element cycles + 1 DONE cycle.

## Test plan
- LR only (mask 0001), no stall → addresses 0..22499 in order; `lineReset` at 149, 299, …, 22499 (150 pulses); `done` pulses exactly 22501 cycles after `start`.
- UD only (mask 0010) → 0, 150, …, 22350 (`lineReset`), 1, 151, …; last address 22499 with `lineReset`.
- DL only (mask 0100) → 0 (`lineReset`); 1, 150 (`lineReset`); 2, 151, 300 (`lineReset`); … final diagonal is 22499 alone; 299 `lineReset` pulses.
- DR only (mask 1000) → 22350 (`lineReset`); 22200, 22351 (`lineReset`); … final element 149 with `lineReset`; mask 1111 → the four passes run back-to-back with `passMode` 0→1→2→3 and no gap cycles.
- Random `stall` bursts on mask 1111 → accepted-address stream is identical to the no-stall stream; `addr` stable throughout every stall.
- Edge cases:
  - `abort` mid-UD → IDLE next cycle, no `done`.
  - `resetIn` mid-DL → all outputs zero immediately.
  - `start` while `busy` → ignored.
  - mask 0000 → `done` one cycle after `start`, with no elements issued.

Source files
------------

// File: rtl/scan_sequencer.sv
// Scan-order controller: issues row-major, column-major and both diagonal
// pixel-address streams under a valid/stall handshake, flagging each line end.
module scan_sequencer #(
    parameter int N      = 150,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        modeMask,
    input  logic              stall,
    output logic [ADDR_W-1:0] addr,
    output logic              addrValid,
    output logic              lineReset,
    output logic [1:0]        passMode,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LR,
        ST_UD,
        ST_DL,
        ST_DR,
        ST_DONE
    } state_t;

    localparam logic [7:0]        LAST   = 8'(N - 1);
    localparam logic [8:0]        LAST_K = 9'(N - 1);
    localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(N);

    state_t              state_q, state_d;
    logic [3:0]          mask_q, mask_d;
    logic [7:0]          row_q, row_d;
    logic [7:0]          col_q, col_d;
    logic [8:0]          k_q, k_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                line_q, line_d;
    logic [1:0]          pass_q, pass_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic                pass_last;
    logic                load;
    logic [2:0]          sel;
    logic [8:0]          k_n;
    logic [8:0]          k_over;
    logic [8:0]          k_under;

    // Lowest enabled pass index >= from; 4 means no pass remains.
    function automatic logic [2:0] first_pass(input logic [3:0] mask, input logic [2:0] from);
        first_pass = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(from) && mask[i]) first_pass = 3'(i);
        end
    endfunction

    function automatic logic line_end(input logic [1:0] pass, input logic [7:0] row,
                                      input logic [7:0] col);
        case (pass)
            2'd0:    line_end = (col == LAST);
            2'd1:    line_end = (row == LAST);
            2'd2:    line_end = (row == LAST) || (col == 8'd0);
            default: line_end = (row == LAST) || (col == LAST);
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        valid_d = valid_q;
        pass_d  = pass_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        sel     = 3'd4;

        accept  = valid_q && !stall;
        k_n     = k_q + 9'd1;
        k_over  = k_n - LAST_K;
        k_under = LAST_K - k_n;
        // The DR pass ends in the top-right corner; all others end bottom-right.
        pass_last = (pass_q == 2'd3) ? (row_q == 8'd0 && col_q == LAST)
                                     : (row_q == LAST && col_q == LAST);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d = modeMask;
                    sel    = first_pass(modeMask, 3'd0);
                    load   = 1'b1;
                end
            end
            ST_LR, ST_UD, ST_DL, ST_DR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (accept) begin
                    if (pass_last) begin
                        sel  = first_pass(mask_q, {1'b0, pass_q} + 3'd1);
                        load = 1'b1;
                    end else begin
                        case (pass_q)
                            2'd0: begin
                                if (col_q == LAST) begin
                                    row_d = row_q + 8'd1;
                                    col_d = 8'd0;
                                end else begin
                                    col_d = col_q + 8'd1;
                                end
                            end
                            2'd1: begin
                                if (row_q == LAST) begin
                                    col_d = col_q + 8'd1;
                                    row_d = 8'd0;
                                end else begin
                                    row_d = row_q + 8'd1;
                                end
                            end
                            2'd2: begin
                                if (line_q) begin
                                    k_d = k_n;
                                    if (k_n <= LAST_K) begin
                                        row_d = 8'd0;
                                        col_d = k_n[7:0];
                                    end else begin
                                        row_d = k_over[7:0];
                                        col_d = LAST;
                                    end
                                end else begin
                                    row_d = row_q + 8'd1;
                                    col_d = col_q - 8'd1;
                                end
                            end
                            default: begin
                                if (line_q) begin
                                    k_d = k_n;
                                    if (k_n <= LAST_K) begin
                                        row_d = k_under[7:0];
                                        col_d = 8'd0;
                                    end else begin
                                        row_d = 8'd0;
                                        col_d = k_over[7:0];
                                    end
                                end else begin
                                    row_d = row_q + 8'd1;
                                    col_d = col_q + 8'd1;
                                end
                            end
                        endcase
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Entering a pass (or finishing) loads the first element of that pass.
        if (load) begin
            if (sel[2]) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end else begin
                state_d = state_t'(sel + 3'd1);
                pass_d  = sel[1:0];
                valid_d = 1'b1;
                busy_d  = 1'b1;
                k_d     = 9'd0;
                row_d   = (sel[1:0] == 2'd3) ? LAST : 8'd0;
                col_d   = 8'd0;
            end
        end

        addr_d = ADDR_W'(row_d) * N_A + ADDR_W'(col_d);
        line_d = valid_d && line_end(pass_d, row_d, col_d);
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            state_q <= ST_IDLE;
            mask_q  <= 4'd0;
            row_q   <= 8'd0;
            col_q   <= 8'd0;
            k_q     <= 9'd0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            line_q  <= 1'b0;
            pass_q  <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            row_q   <= row_d;
            col_q   <= col_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            line_q  <= line_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign addr      = addr_q;
    assign addrValid = valid_q;
    assign lineReset = line_q;
    assign passMode  = pass_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer on a 10x10 image: per-feature tasks compare
// the accepted address stream against a reference built from the scan definitions.
module tb_scan_sequencer;

    localparam int N      = 10;
    localparam int ADDR_W = 7;
    localparam int BUDGET = 4 * N * N * 6 + 100;

    logic              clk;
    logic              resetIn;
    logic              start;
    logic              abort;
    logic [3:0]        modeMask;
    logic              stall;
    logic [ADDR_W-1:0] addr;
    logic              addrValid;
    logic              lineReset;
    logic [1:0]        passMode;
    logic              busy;
    logic              done;

    int tests_run    = 0;
    int tests_failed = 0;
    int last_pulses  = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              le;
        logic [1:0]        pm;
    } elem_t;

    elem_t             exp_q[$];
    logic [ADDR_W-1:0] got_q[$];

    scan_sequencer #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .resetIn   (resetIn),
        .start     (start),
        .abort     (abort),
        .modeMask  (modeMask),
        .stall     (stall),
        .addr      (addr),
        .addrValid (addrValid),
        .lineReset (lineReset),
        .passMode  (passMode),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic elem_t mk(input int r, input int c, input bit le, input int pm);
        elem_t e;
        e.addr = ADDR_W'(r * N + c);
        e.le   = le;
        e.pm   = 2'(pm);
        return e;
    endfunction

    // Reference stream straight from the pass definitions (row/col/diagonal enumeration).
    task automatic build_expected(input logic [3:0] mask);
        exp_q.delete();
        if (mask[0])
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) exp_q.push_back(mk(r, c, c == N - 1, 0));
        if (mask[1])
            for (int c = 0; c < N; c++)
                for (int r = 0; r < N; r++) exp_q.push_back(mk(r, c, r == N - 1, 1));
        if (mask[2])
            for (int k = 0; k <= 2 * N - 2; k++) begin
                int r0 = (k > N - 1) ? k - N + 1 : 0;
                for (int r = r0; r < N && k - r >= 0; r++)
                    exp_q.push_back(mk(r, k - r, (r == N - 1) || (k - r == 0), 2));
            end
        if (mask[3])
            for (int k = 0; k <= 2 * N - 2; k++) begin
                int r0 = (k < N - 1) ? N - 1 - k : 0;
                for (int r = r0; r < N && r + k - (N - 1) < N; r++)
                    exp_q.push_back(mk(r, r + k - (N - 1),
                                       (r == N - 1) || (r + k - (N - 1) == N - 1), 3));
            end
    endtask

    task automatic run_seq(input logic [3:0] mask, input bit use_stall, input bit poke_start,
                           input string name);
        int idx = 0, cycles = 1, stall_left = 0;
        bit finished = 0, held = 0;
        logic [ADDR_W-1:0] h_addr = '0;
        logic h_le = 1'b0;
        logic [1:0] h_pm = 2'd0;
        build_expected(mask);
        got_q.delete();
        last_pulses = 0;
        modeMask = mask; start = 1'b1; stall = 1'b0;
        tick();
        start = 1'b0; modeMask = 4'd0;
        while (!finished && cycles < BUDGET) begin
            if (held) begin
                tests_run++;
                if (addr !== h_addr || lineReset !== h_le || passMode !== h_pm || addrValid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s hold: got addr=%0d lr=%0b pm=%0d v=%0b, want addr=%0d lr=%0b pm=%0d v=1",
                             name, addr, lineReset, passMode, addrValid, h_addr, h_le, h_pm);
                end
                held = 0;
            end
            if (done === 1'b1) begin
                finished = 1;
            end else begin
                tests_run++;
                if (addrValid !== 1'b1 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s valid/busy at cycle %0d: got v=%0b busy=%0b, want 1/1",
                             name, cycles, addrValid, busy);
                end
                if (poke_start && cycles == 3) begin
                    start = 1'b1; modeMask = 4'hF;
                end else begin
                    start = 1'b0; modeMask = 4'd0;
                end
                stall = 1'b0;
                if (use_stall) begin
                    if (stall_left > 0) begin
                        stall = 1'b1; stall_left--;
                    end else if ($urandom_range(0, 5) == 0) begin
                        stall = 1'b1; stall_left = $urandom_range(0, 4);
                    end
                end
                if (addrValid === 1'b1 && !stall) begin
                    tests_run++;
                    if (idx >= exp_q.size()) begin
                        tests_failed++;
                        $display("FAIL %s overrun: got extra addr=%0d, want no more elements", name, addr);
                    end else if (addr !== exp_q[idx].addr || lineReset !== exp_q[idx].le ||
                                 passMode !== exp_q[idx].pm) begin
                        tests_failed++;
                        $display("FAIL %s elem %0d: got addr=%0d lr=%0b pm=%0d, want addr=%0d lr=%0b pm=%0d",
                                 name, idx, addr, lineReset, passMode,
                                 exp_q[idx].addr, exp_q[idx].le, exp_q[idx].pm);
                    end
                    got_q.push_back(addr);
                    if (lineReset === 1'b1) last_pulses++;
                    idx++;
                end else if (stall) begin
                    held = 1; h_addr = addr; h_le = lineReset; h_pm = passMode;
                end
                tick();
                cycles++;
            end
        end
        stall = 1'b0; start = 1'b0; modeMask = 4'd0;
        tests_run++;
        if (!finished) begin
            tests_failed++;
            $display("FAIL %s timeout: got no done within %0d cycles, want done", name, BUDGET);
        end else begin
            tests_run++;
            if (idx != exp_q.size()) begin
                tests_failed++;
                $display("FAIL %s count: got %0d elements, want %0d", name, idx, exp_q.size());
            end
            if (!use_stall) begin
                tests_run++;
                if (cycles != exp_q.size() + 1) begin
                    tests_failed++;
                    $display("FAIL %s latency: got done %0d cycles after start, want %0d",
                             name, cycles, exp_q.size() + 1);
                end
            end
            if (busy !== 1'b0 || addrValid !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s done cycle: got busy=%0b v=%0b, want 0/0", name, busy, addrValid);
            end
            tick();
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0 || addrValid !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s after done: got done=%0b busy=%0b v=%0b, want 0/0/0",
                         name, done, busy, addrValid);
            end
        end
    endtask

    task automatic check_pulses(input int want, input string name);
        tests_run++;
        if (last_pulses != want) begin
            tests_failed++;
            $display("FAIL %s lineReset count: got %0d, want %0d", name, last_pulses, want);
        end
    endtask

    task automatic check_prefix(input logic [ADDR_W-1:0] want[6], input logic [ADDR_W-1:0] want_last,
                                input string name);
        tests_run++;
        if (got_q.size() < 6) begin
            tests_failed++;
            $display("FAIL %s prefix: got %0d elements, want at least 6", name, got_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (got_q[i] !== want[i]) begin
                    tests_failed++;
                    $display("FAIL %s prefix[%0d]: got %0d, want %0d", name, i, got_q[i], want[i]);
                end
            end
            if (got_q[got_q.size() - 1] !== want_last) begin
                tests_failed++;
                $display("FAIL %s last: got %0d, want %0d", name, got_q[got_q.size() - 1], want_last);
            end
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (addr !== '0 || addrValid !== 1'b0 || lineReset !== 1'b0 || passMode !== 2'd0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: got addr=%0d v=%0b lr=%0b pm=%0d busy=%0b done=%0b, want all 0",
                     addr, addrValid, lineReset, passMode, busy, done);
        end
    endtask

    task automatic test_lr();
        logic [ADDR_W-1:0] w[6] = '{0, 1, 2, 3, 4, 5};
        run_seq(4'b0001, 0, 0, "lr");
        check_pulses(10, "lr");
        check_prefix(w, 7'd99, "lr");
    endtask

    task automatic test_ud();
        logic [ADDR_W-1:0] w[6] = '{0, 10, 20, 30, 40, 50};
        run_seq(4'b0010, 0, 0, "ud");
        check_pulses(10, "ud");
        check_prefix(w, 7'd99, "ud");
        tests_run++;
        if (got_q.size() < 11 || got_q[9] !== 7'd90 || got_q[10] !== 7'd1) begin
            tests_failed++;
            $display("FAIL ud column wrap: got size=%0d, want [9]=90 [10]=1", got_q.size());
        end
    endtask

    task automatic test_dl();
        logic [ADDR_W-1:0] w[6] = '{0, 1, 10, 2, 11, 20};
        run_seq(4'b0100, 0, 0, "dl");
        check_pulses(19, "dl");
        check_prefix(w, 7'd99, "dl");
    endtask

    task automatic test_dr();
        logic [ADDR_W-1:0] w[6] = '{90, 80, 91, 70, 81, 92};
        run_seq(4'b1000, 0, 0, "dr");
        check_pulses(19, "dr");
        check_prefix(w, 7'd9, "dr");
    endtask

    task automatic test_back_to_back();
        run_seq(4'b1111, 0, 0, "all");
        check_pulses(58, "all");
    endtask

    task automatic test_stall();
        run_seq(4'b1111, 1, 0, "stall");
        check_pulses(58, "stall");
    endtask

    task automatic test_start_busy();
        run_seq(4'b0001, 0, 1, "start_busy");
        check_pulses(10, "start_busy");
    endtask

    task automatic test_abort();
        modeMask = 4'b0010; start = 1'b1;
        tick();
        start = 1'b0; modeMask = 4'd0;
        for (int i = 0; i < 15; i++) tick();
        tests_run++;
        if (addrValid !== 1'b1 || passMode !== 2'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort pre: got v=%0b pm=%0d busy=%0b, want 1/1/1", addrValid, passMode, busy);
        end
        abort = 1'b1; stall = 1'b0;
        tick();
        abort = 1'b0;
        tests_run++;
        if (addrValid !== 1'b0 || busy !== 1'b0 || lineReset !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort: got v=%0b busy=%0b lr=%0b done=%0b, want 0/0/0/0",
                     addrValid, busy, lineReset, done);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (done !== 1'b0 || addrValid !== 1'b0) begin
                tests_failed++;
                $display("FAIL abort idle %0d: got done=%0b v=%0b, want 0/0", i, done, addrValid);
            end
        end
    endtask

    task automatic test_reset_mid();
        modeMask = 4'b0100; start = 1'b1;
        tick();
        start = 1'b0; modeMask = 4'd0;
        for (int i = 0; i < 20; i++) tick();
        tests_run++;
        if (addrValid !== 1'b1 || passMode !== 2'd2) begin
            tests_failed++;
            $display("FAIL reset_mid pre: got v=%0b pm=%0d, want 1/2", addrValid, passMode);
        end
        #2 resetIn = 1'b1;
        #1;
        tests_run++;
        if (addr !== '0 || addrValid !== 1'b0 || lineReset !== 1'b0 || passMode !== 2'd0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got addr=%0d v=%0b lr=%0b pm=%0d busy=%0b done=%0b, want all 0",
                     addr, addrValid, lineReset, passMode, busy, done);
        end
        tick();
        resetIn = 1'b0;
        tick();
        tests_run++;
        if (addrValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid idle: got v=%0b busy=%0b done=%0b, want 0/0/0", addrValid, busy, done);
        end
    endtask

    task automatic test_mask_zero();
        modeMask = 4'b0000; start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || addrValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mask0: got done=%0b busy=%0b v=%0b, want 1/0/0", done, busy, addrValid);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || addrValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mask0 after: got done=%0b v=%0b, want 0/0", done, addrValid);
        end
    endtask

    initial begin
        resetIn = 1'b1; start = 1'b0; abort = 1'b0; modeMask = 4'd0; stall = 1'b0;
        tick();
        tick();
        test_reset();
        resetIn = 1'b0;
        tick();
        test_reset();
        test_lr();
        test_ud();
        test_dl();
        test_dr();
        test_back_to_back();
        test_stall();
        test_start_busy();
        test_abort();
        test_reset_mid();
        test_mask_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
